// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_t BCD_ADJ        = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake plus the four held BCD digits between a requester and bin2bcd_seq.
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int IN_W = 13
);

  logic            start;
  logic [IN_W-1:0] bin;
  logic            busy;
  logic            done;
  bcd_t            thousands;
  bcd_t            hundreds;
  bcd_t            tens;
  bcd_t            ones;

  modport master (
    output start, bin,
    input  busy, done, thousands, hundreds, tens, ones
  );

  modport slave (
    input  start, bin,
    output busy, done, thousands, hundreds, tens, ones
  );

endinterface

// File: rtl/dabble_digit.sv
// One double-dabble correction: adds 3 to a BCD digit that is 5 or more so the next shift carries correctly.
module dabble_digit
  import bin2bcd_pkg::*;
(
  input  bcd_t digit_i,
  output bcd_t digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter: one correct-and-shift step per clock, result held until the next conversion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
) (
  input logic          clk,
  input logic          rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_e             state_q, state_d;
  logic [SCR_W-1:0]   scratch_q, scratch_adj, scratch_sh;
  logic [IN_W-1:0]    shift_q, shift_sh;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCR_W-1:0]   result_q;
  logic               last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    dabble_digit u_digit (
      .digit_i(scratch_q[4*g +: 4]),
      .digit_o(scratch_adj[4*g +: 4])
    );
  end

  // Corrected scratch and the binary register shift as one vector so the MSB of shift_q enters digit 0.
  always_comb begin
    {scratch_sh, shift_sh} = {scratch_adj, shift_q} << 1;
  end

  assign last_iter = (cnt_q == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == SHIFT);
    bus.done = (state_q == DONE);
  end

  // NOTE: datapath registers are reset as well, so an abandoned conversion leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q   <= bus.bin;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(IN_W);
          end
        end
        SHIFT: begin
          scratch_q <= scratch_sh;
          shift_q   <= shift_sh;
          cnt_q     <= cnt_q - 1'b1;
          if (last_iter) result_q <= scratch_sh;
        end
        default: ;
      endcase
    end
  end

  assign bus.thousands = result_q[12 +: 4];
  assign bus.hundreds  = result_q[8 +: 4];
  assign bus.tens      = result_q[4 +: 4];
  assign bus.ones      = result_q[0 +: 4];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a transaction model queues expected digits, a negedge monitor checks them.
module tb_bin2bcd_seq;

  localparam int IN_W    = 13;
  localparam int LATENCY = 13;

  typedef struct {
    logic [15:0] bcd;
    int          acc;
  } sb_entry_t;

  logic clk;
  logic rst_n;

  bin2bcd_seq_if #(.IN_W(IN_W)) bus ();

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          m_cnt = 0;
  int          prev_done = -1;
  int          last_gap = 0;
  logic [15:0] held = '0;
  sb_entry_t   sb[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: a start seen while idle is accepted, then the converter is unavailable for 14 edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      sb.delete();
    end else if (m_cnt == 0) begin
      if (bus.start) begin
        sb.push_back('{bcd: ref_bcd(int'(bus.bin)), acc: cyc});
        m_cnt <= LATENCY + 1;
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk) begin : monitor
    sb_entry_t   e;
    logic [15:0] got;
    got = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
    if (!rst_n) begin
      held <= '0;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_digits", int'(got), 0);
    end else begin
      check("busy", int'(bus.busy), int'(m_cnt >= 2));
      check("done", int'(bus.done), int'(m_cnt == 1));
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("digits", int'(got), int'(e.bcd));
          check("latency", cyc - e.acc - 1, LATENCY);
          held      <= e.bcd;
          last_gap  <= cyc - prev_done;
          prev_done <= cyc;
        end
      end else begin
        check("hold", int'(got), int'(held));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic convert(input int v);
    @(negedge clk);
    bus.bin   = IN_W'(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    idle(2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] got;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    got = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
    check("idle_digits", int'(got), 0);

    // Single conversions, including the extremes and digit-boundary values
    convert(0);
    convert(8191);
    convert(1234);
    convert(9);
    convert(10);

    // A second start and a changed bin while busy are ignored
    @(negedge clk);
    bus.bin   = IN_W'(4095);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    idle(4);
    bus.bin   = IN_W'(77);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    idle(20);
    got = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
    check("ignored_start", int'(got), int'(ref_bcd(4095)));

    // Start held high: back-to-back conversions every IN_W+2 cycles
    @(negedge clk);
    bus.bin   = IN_W'(100);
    bus.start = 1'b1;
    @(negedge clk);
    bus.bin   = IN_W'(200);
    repeat (15) @(negedge clk);
    bus.start = 1'b0;
    drain();
    check("done_gap", last_gap, LATENCY + 2);
    idle(2);

    // Asynchronous reset mid-conversion abandons it without a done pulse
    @(negedge clk);
    bus.bin   = IN_W'(5555);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
    check("async_digits", int'(got), 0);
    check("async_busy", int'(bus.busy), 0);
    check("async_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    convert(5555);
    got = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
    check("after_reset", int'(got), int'(ref_bcd(5555)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
